mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_if.sv | 34 +++
 rtl/mem_arb.sv | 155 +++++++++++++++
 tb/tb_mem_arb.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Request, response and memory-side signals of the two-requester memory arbiter.
// The arbiter takes the slave modport; the requesters and the memory take the master modport.
interface mem_arb_if;
  logic        req_i;
  logic        req_d;
  logic [31:0] addr_i;
  logic [31:0] addr_d;
  logic        we_d;
  logic [31:0] wdata_d;
  logic        gnt_i;
  logic        gnt_d;
  logic        rvalid_i;
  logic        rvalid_d;
  logic [31:0] rdata;
  logic        done_i;
  logic        done_d;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_i, req_d, addr_i, addr_d, we_d, wdata_d, mem_rdata,
    output gnt_i, gnt_d, rvalid_i, rvalid_d, rdata, done_i, done_d,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_i, req_d, addr_i, addr_d, we_d, wdata_d, mem_rdata,
    input  gnt_i, gnt_d, rvalid_i, rvalid_d, rdata, done_i, done_d,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb.sv
// Icache/dcache arbiter for one fixed-latency memory: 4-beat reads, single-word dcache writes.
// Define MEM_ARB_FIXED_PRI_EN to give the icache fixed priority instead of round-robin.
module mem_arb #(
  parameter int unsigned LAT = 3
) (
  input logic       clk,
  input logic       rstn,
  mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic           owner_q, owner_d;  // 1: dcache owns the transaction
  logic           wr_q, wr_d;
  logic [14:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic           win_i, win_d;
  logic           gnt_i, gnt_d;
  logic           mem_en, mem_we;
  logic           push, push_last, done_wr;
  logic [LAT-1:0] tag_vld_q, tag_own_q, tag_last_q;
  logic           tail_vld, tail_own, tail_last;

`ifdef MEM_ARB_FIXED_PRI_EN
  assign win_i = bus.req_i;
  assign win_d = bus.req_d & ~bus.req_i;
`else
  logic ptr_q;  // 1: dcache wins the next tie

  assign win_i = bus.req_i & (~bus.req_d | ~ptr_q);
  assign win_d = bus.req_d & (~bus.req_i | ptr_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 1'b0;
    end else if (gnt_i || gnt_d) begin
      ptr_q <= gnt_i;
    end
  end
`endif

  // Grants are combinational, so they are also gated by reset.
  assign gnt_i = rstn & (state_q == StIdle) & win_i;
  assign gnt_d = rstn & (state_q == StIdle) & win_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    done_wr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_i || gnt_d) begin
          state_d = StIssue;
          beat_d  = 2'd0;
          owner_d = gnt_d;
          wr_d    = gnt_d & bus.we_d;
          if (gnt_d && bus.we_d) begin
            mem_addr_d  = bus.addr_d[16:2];
            mem_wdata_d = bus.wdata_d;
          end else if (gnt_d) begin
            mem_addr_d = {bus.addr_d[16:4], 2'b00};
          end else begin
            mem_addr_d = {bus.addr_i[16:4], 2'b00};
          end
        end
      end
      StIssue: begin
        mem_en = 1'b1;
        mem_we = wr_q;
        if (wr_q) begin
          done_wr = 1'b1;
          state_d = StIdle;
        end else begin
          push      = 1'b1;
          push_last = (beat_q == 2'd3);
          if (beat_q == 2'd3) begin
            state_d = StDrain;
          end else begin
            beat_d     = beat_q + 2'd1;
            mem_addr_d = {mem_addr_q[14:2], beat_q + 2'd1};
          end
        end
      end
      StDrain: begin
        if (tail_vld && tail_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Return tags travel alongside the memory pipeline and surface exactly LAT cycles after issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
      tag_last_q <= '0;
    end else begin
      tag_vld_q[0]  <= push;
      tag_own_q[0]  <= owner_q;
      tag_last_q[0] <= push_last;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_own_q[i]  <= tag_own_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  assign tail_vld  = tag_vld_q[LAT-1];
  assign tail_own  = tag_own_q[LAT-1];
  assign tail_last = tag_last_q[LAT-1];

  assign bus.gnt_i     = gnt_i;
  assign bus.gnt_d     = gnt_d;
  assign bus.rvalid_i  = tail_vld & ~tail_own;
  assign bus.rvalid_d  = tail_vld & tail_own;
  assign bus.done_i    = tail_vld & ~tail_own & tail_last;
  assign bus.done_d    = (tail_vld & tail_own & tail_last) | done_wr;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: one instance at LAT=3, one at LAT=1, shared clock and reset.
module tb_mem_arb;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  mem_arb_if ba ();
  mem_arb_if bb ();

  mem_arb #(.LAT(LAT_A)) u_dut_a (.clk(clk), .rstn(rstn), .bus(ba));
  mem_arb #(.LAT(LAT_B)) u_dut_b (.clk(clk), .rstn(rstn), .bus(bb));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        own;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return 32'hC0DE_0000 ^ {a, 2'b01, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void push_rd(input bit to_b, input logic own, input logic [31:0] addr);
    for (int b = 0; b < 4; b++) begin
      exp_t e;
      e.own  = own;
      e.data = mem_word({addr[16:4], 2'(b)});
      e.last = (b == 3);
      if (to_b) sb_b.push_back(e);
      else sb_a.push_back(e);
    end
  endfunction

  // Memory models: fixed-latency read pipelines fed by the DUT's issue cycles.
  logic [31:0] pipe_a [LAT_A];
  logic [31:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    pipe_a[0] <= (ba.mem_en && !ba.mem_we) ? mem_word(ba.mem_addr) : 32'h0BAD_0BAD;
    pipe_b[0] <= (bb.mem_en && !bb.mem_we) ? mem_word(bb.mem_addr) : 32'h0BAD_0BAD;
    for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
    for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
  end

  assign ba.mem_rdata = pipe_a[LAT_A-1];
  assign bb.mem_rdata = pipe_b[LAT_B-1];

  always @(negedge clk) begin
    if (ba.rvalid_i || ba.rvalid_d) begin
      if (sb_a.size() == 0) begin
        check("a_extra_beat", 32'({ba.rvalid_d, ba.rvalid_i}), 32'd0);
      end else begin
        exp_t e;
        e = sb_a.pop_front();
        check("a_owner", 32'({ba.rvalid_d, ba.rvalid_i}), e.own ? 32'd2 : 32'd1);
        check("a_rdata", ba.rdata, e.data);
        check("a_done", 32'({ba.done_d, ba.done_i}), e.last ? (e.own ? 32'd2 : 32'd1) : 32'd0);
      end
    end
    if (bb.rvalid_i || bb.rvalid_d) begin
      if (sb_b.size() == 0) begin
        check("b_extra_beat", 32'({bb.rvalid_d, bb.rvalid_i}), 32'd0);
      end else begin
        exp_t e;
        e = sb_b.pop_front();
        check("b_owner", 32'({bb.rvalid_d, bb.rvalid_i}), e.own ? 32'd2 : 32'd1);
        check("b_rdata", bb.rdata, e.data);
        check("b_done", 32'({bb.done_d, bb.done_i}), e.last ? (e.own ? 32'd2 : 32'd1) : 32'd0);
      end
    end
  end

  task automatic idle_inputs();
    ba.req_i = 1'b0; ba.req_d = 1'b0; ba.addr_i = '0; ba.addr_d = '0;
    ba.we_d  = 1'b0; ba.wdata_d = '0;
    bb.req_i = 1'b0; bb.req_d = 1'b0; bb.addr_i = '0; bb.addr_d = '0;
    bb.we_d  = 1'b0; bb.wdata_d = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags_a"}, 32'({ba.gnt_i, ba.gnt_d, ba.rvalid_i, ba.rvalid_d,
                                  ba.done_i, ba.done_d, ba.mem_en, ba.mem_we}), 32'd0);
    check({tag, "_flags_b"}, 32'({bb.gnt_i, bb.gnt_d, bb.rvalid_i, bb.rvalid_d,
                                  bb.done_i, bb.done_d, bb.mem_en, bb.mem_we}), 32'd0);
    check({tag, "_addr_a"}, 32'(ba.mem_addr), 32'd0);
    check({tag, "_wdata_a"}, ba.mem_wdata, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    sb_a.delete();
    sb_b.delete();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && (sb_a.size() != 0 || sb_b.size() != 0); i++) @(negedge clk);
    check(tag, 32'(sb_a.size() + sb_b.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  e_gnt;
    logic [1:0]  e_ew;
    logic [2:0]  e_rv;
    logic [14:0] e_addr;
    logic [31:0] e_wd;

    idle_inputs();
    #1 rstn = 1'b0;

    // Reset holds grants low even with both requests raised.
    repeat (2) @(negedge clk);
    ba.req_i = 1'b1; ba.req_d = 1'b1; bb.req_d = 1'b1;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    idle_inputs();
    rstn = 1'b1;
    @(negedge clk);

    // Icache read at 0x1238, dcache write queued behind it, then a wrap-edge icache read.
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      ba.req_i   = (c == 0 || c == 10);
      ba.addr_i  = (c < 10) ? 32'h0000_1238 : 32'h0007_FFF0;
      ba.req_d   = (c >= 2 && c <= 8);
      ba.we_d    = 1'b1;
      ba.addr_d  = 32'h0000_0040;
      ba.wdata_d = 32'hDEAD_BEEF;
      if (c == 0) push_rd(1'b0, 1'b0, 32'h0000_1238);
      if (c == 10) push_rd(1'b0, 1'b0, 32'h0007_FFF0);
      #1;
      e_gnt = {(c == 0 || c == 10), (c == 8)};
      e_ew  = {((c >= 1 && c <= 4) || c == 9 || c == 11), (c == 9)};
      e_rv  = {(c >= 4 && c <= 7), (c == 7), (c == 9)};
      if (c == 0) e_addr = 15'h0;
      else if (c <= 4) e_addr = 15'h48C + 15'(c - 1);
      else if (c <= 8) e_addr = 15'h48F;
      else if (c <= 10) e_addr = 15'h010;
      else e_addr = 15'h7FFC;
      e_wd = (c >= 9) ? 32'hDEAD_BEEF : 32'h0;
      check("s1_gnt", 32'({ba.gnt_i, ba.gnt_d}), 32'(e_gnt));
      check("s1_en_we", 32'({ba.mem_en, ba.mem_we}), 32'(e_ew));
      check("s1_rv_done", 32'({ba.rvalid_i, ba.done_i, ba.done_d}), 32'(e_rv));
      check("s1_mem_addr", 32'(ba.mem_addr), 32'(e_addr));
      check("s1_mem_wdata", ba.mem_wdata, e_wd);
    end
    idle_inputs();
    wait_drain("s1_drain");

    // Simultaneous requests straight after reset: icache first, then the arbitration winner.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      ba.req_i  = (c <= 8);
      ba.addr_i = 32'h0000_0100;
      ba.req_d  = (c <= 8);
      ba.we_d   = 1'b0;
      ba.addr_d = 32'h0000_2000;
      e_gnt = 2'b00;
      if (c == 0) begin
        push_rd(1'b0, 1'b0, 32'h0000_0100);
        e_gnt = 2'b10;
      end
      if (c == 8) begin
`ifdef MEM_ARB_FIXED_PRI_EN
        push_rd(1'b0, 1'b0, 32'h0000_0100);
        e_gnt = 2'b10;
`else
        push_rd(1'b0, 1'b1, 32'h0000_2000);
        e_gnt = 2'b01;
`endif
      end
      #1;
      check("s2_gnt", 32'({ba.gnt_i, ba.gnt_d}), 32'(e_gnt));
    end
    idle_inputs();
    wait_drain("s2_drain");

    // Reset during beat 2 of an icache read kills the transaction outright.
    @(negedge clk);
    ba.req_i  = 1'b1;
    ba.addr_i = 32'h0000_5550;
    push_rd(1'b0, 1'b0, 32'h0000_5550);
    #1;
    check("s3_gnt", 32'({ba.gnt_i, ba.gnt_d}), 32'd2);
    @(negedge clk);
    ba.req_i = 1'b0;
    #1;
    check("s3_beat0_addr", 32'(ba.mem_addr), 32'h1554);
    repeat (2) @(negedge clk);
    #1;
    check("s3_beat2_addr", 32'(ba.mem_addr), 32'h1556);
    rstn = 1'b0;
    sb_a.delete();
    #1;
    check_reset_outputs("s3_mid");
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check("s3_no_rvalid", 32'({ba.rvalid_i, ba.rvalid_d, ba.done_i, ba.done_d}), 32'd0);
    end

    // Fresh dcache read is granted; a one-cycle icache pulse while busy is never granted.
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      ba.req_d  = (c == 0);
      ba.we_d   = 1'b0;
      ba.addr_d = 32'h0000_3000;
      ba.req_i  = (c == 2);
      ba.addr_i = 32'h0000_9990;
      if (c == 0) push_rd(1'b0, 1'b1, 32'h0000_3000);
      #1;
      check("s4_gnt", 32'({ba.gnt_i, ba.gnt_d}), (c == 0) ? 32'd1 : 32'd0);
    end
    idle_inputs();
    wait_drain("s4_drain");

    // LAT=1 instance: three back-to-back dcache reads.
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      bb.req_d  = (c <= 12);
      bb.we_d   = 1'b0;
      bb.addr_d = 32'(c / 6 + 1) << 8;
      if (c % 6 == 0 && c <= 12) push_rd(1'b1, 1'b1, 32'(c / 6 + 1) << 8);
      #1;
      check("b_gnt", 32'(bb.gnt_d), 32'(c % 6 == 0 && c <= 12));
      check("b_mem_en", 32'(bb.mem_en), 32'(c % 6 >= 1 && c % 6 <= 4));
      check("b_rvalid", 32'(bb.rvalid_d), 32'(c % 6 >= 2));
    end
    idle_inputs();
    wait_drain("b_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
